// File: rtl/racing_game_engine_pkg.sv
// Shared game-state encodings, enemy slot layout and small helpers for the
// racing game engine.
package racing_game_engine_pkg;

    localparam int ENEMY_W = 8;

    localparam logic [1:0] ST_ATTRACT  = 2'd0;
    localparam logic [1:0] ST_PLAY     = 2'd1;
    localparam logic [1:0] ST_CRASH    = 2'd2;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

    localparam logic [7:0] ATTRACT_SPEED = 8'd31;
    localparam logic [7:0] LFSR_SEED     = 8'h01;

    typedef struct packed {
        logic [ENEMY_W-1:0] x;
        logic [ENEMY_W-1:0] y;
        logic               dir;  // 1 = moving right
    } enemy_t;

    function automatic logic [7:0] clamp8(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/racing_game_engine_lfsr8.sv
// 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, used to pick enemy respawn x.
module lfsr8
    import racing_game_engine_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q, lfsr_d;
    logic       fb;

    assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d = en_i ? {lfsr_q[6:0], fb} : lfsr_q;
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/racing_game_engine.sv
// Per-frame game-state engine: player, bouncing enemies, scroll, speed,
// score, lives and the attract/play/crash/game-over FSM.
module racing_game_engine
    import racing_game_engine_pkg::*;
#(
    parameter int NUM_ENEMIES  = 2,
    parameter int LEFT_EDGE    = 64,
    parameter int RIGHT_EDGE   = 192,
    parameter int PLAYER_Y     = 180,
    parameter int START_LIVES  = 3,
    parameter int CRASH_SPEED  = 16,
    parameter int CRASH_FRAMES = 60,
    parameter int SCORE_W      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     frame_tick_i,
    input  logic [7:0]               paddle_x_i,
    input  logic [7:0]               paddle_y_i,
    input  logic                     start_btn_i,
    input  logic                     player_gfx_i,
    input  logic [NUM_ENEMIES-1:0]   enemy_gfx_i,
    input  logic                     track_gfx_i,
    output logic [7:0]               player_x_o,
    output logic [7:0]               player_y_o,
    output logic [8*NUM_ENEMIES-1:0] enemy_x_o,
    output logic [8*NUM_ENEMIES-1:0] enemy_y_o,
    output logic [15:0]              track_pos_o,
    output logic [7:0]               speed_o,
    output logic [SCORE_W-1:0]       score_o,
    output logic [2:0]               lives_o,
    output logic [1:0]               game_state_o
);

    localparam logic [7:0] LEFT_X    = 8'(LEFT_EDGE);
    localparam logic [7:0] RIGHT_X   = 8'(RIGHT_EDGE);
    localparam logic [7:0] PMAX_X    = 8'(RIGHT_EDGE - 8);
    localparam logic [2:0] LIVES0    = 3'(START_LIVES);
    localparam logic [7:0] CRASH_SPD = 8'(CRASH_SPEED);
    localparam logic [7:0] CRASH_T   = 8'(CRASH_FRAMES);

    logic [1:0]             state_q, state_d;
    logic [7:0]             player_x_q, player_x_d;
    logic [7:0]             speed_q, speed_d;
    logic [7:0]             timer_q, timer_d;
    logic [15:0]            track_q, track_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [2:0]             lives_q, lives_d;
    logic                   hit_q, hit_d;

    logic [7:0]             lfsr;
    logic [8:0]             reload_sum;
    logic [7:0]             reload_x;
    logic                   moving;
    logic [3:0]             step;
    logic [NUM_ENEMIES-1:0] wrap;
    logic [2:0]             wrap_cnt;
    logic [SCORE_W:0]       score_sum;
    logic [SCORE_W-1:0]     score_sat;
    logic [7:0]             target, speed_step;

    lfsr8 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    // A hit seen in the frame_tick cycle itself must survive into the next frame.
    assign hit_d = (player_gfx_i && (|enemy_gfx_i || track_gfx_i)) || (hit_q && !frame_tick_i);

    assign moving     = (state_q != ST_GAMEOVER);
    assign step       = (state_q == ST_ATTRACT) ? ATTRACT_SPEED[7:4] : speed_q[7:4];
    assign reload_sum = {1'b0, LEFT_X} + {1'b0, lfsr & 8'h7F};
    assign reload_x   = (reload_sum > {1'b0, PMAX_X}) ? PMAX_X : reload_sum[7:0];

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_enemy
        localparam logic [7:0] RST_X   = 8'(LEFT_EDGE + 32 * g);
        localparam logic [7:0] RST_Y   = 8'(g * (256 / NUM_ENEMIES));
        localparam logic       RST_DIR = (g % 2) == 1;

        enemy_t     en_q, en_d;
        logic [7:0] y_nxt;

        assign y_nxt   = en_q.y + {4'd0, step};
        assign wrap[g] = moving && (y_nxt < en_q.y);

        // A respawn after passing the player takes priority over the edge bounce.
        always_comb begin
            en_d = en_q;
            if (moving) begin
                en_d.y = y_nxt;
                if (y_nxt < en_q.y) begin
                    en_d.x = reload_x;
                end else if (en_q.x == LEFT_X) begin
                    en_d.dir = 1'b1;
                    en_d.x   = LEFT_X + 8'd1;
                end else if (en_q.x == RIGHT_X) begin
                    en_d.dir = 1'b0;
                    en_d.x   = RIGHT_X - 8'd1;
                end else begin
                    en_d.x = en_q.dir ? en_q.x + 8'd1 : en_q.x - 8'd1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)           en_q <= '{x: RST_X, y: RST_Y, dir: RST_DIR};
            else if (frame_tick_i) en_q <= en_d;
        end

        assign enemy_x_o[8*g +: 8] = en_q.x;
        assign enemy_y_o[8*g +: 8] = en_q.y;
    end

    always_comb begin
        wrap_cnt = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) wrap_cnt = wrap_cnt + {2'b00, wrap[i]};
    end

    assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(wrap_cnt);
    assign score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign target     = ~paddle_y_i;
    assign speed_step = (speed_q < target) ? speed_q + 8'd1 :
                        (speed_q > target) ? speed_q - 8'd1 : speed_q;

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        track_d    = moving ? track_q + {12'd0, step} : track_q;
        score_d    = score_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        player_x_d = clamp8(paddle_x_i, LEFT_X, PMAX_X);
        case (state_q)
            ST_ATTRACT, ST_GAMEOVER: begin
                if (state_q == ST_ATTRACT) speed_d = ATTRACT_SPEED;
                if (start_btn_i) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES0;
                    score_d = '0;
                    speed_d = '0;
                end
            end
            ST_PLAY: begin
                speed_d = speed_step;
                score_d = score_sat;
                if (hit_q) begin
                    speed_d = CRASH_SPD;
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    timer_d = CRASH_T;
                    state_d = (lives_q <= 3'd1) ? ST_GAMEOVER : ST_CRASH;
                end
            end
            default: begin
                speed_d = speed_step;
                score_d = score_sat;
                timer_d = timer_q - 8'd1;
                if (timer_q <= 8'd1) begin
                    timer_d = '0;
                    state_d = ST_PLAY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hit_q <= 1'b0;
        else         hit_q <= hit_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ATTRACT;
            player_x_q <= LEFT_X;
            speed_q    <= '0;
            track_q    <= '0;
            score_q    <= '0;
            lives_q    <= LIVES0;
            timer_q    <= '0;
        end else if (frame_tick_i) begin
            state_q    <= state_d;
            player_x_q <= player_x_d;
            speed_q    <= speed_d;
            track_q    <= track_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            timer_q    <= timer_d;
        end
    end

    assign player_x_o   = player_x_q;
    assign player_y_o   = 8'(PLAYER_Y);
    assign track_pos_o  = track_q;
    assign speed_o      = speed_q;
    assign score_o      = score_q;
    assign lives_o      = lives_q;
    assign game_state_o = state_q;

endmodule
